// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetch PC and instruction word, precomputes PC+4,
// honours stall (hold) and flush (bubble), and keeps saturating stall/flush counters.
module if_id_reg #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP   = 32'h00000000,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] instr_in,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4_out,
    output logic [WIDTH-1:0] instr_out,
    output logic             valid_out,
    output logic             addr_err_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [WIDTH-1:0] pc_p1;
    logic [WIDTH-1:0] pc4_p1;
    logic [WIDTH-1:0] instr_p1;
    logic             vld_p1;
    logic             err_p1;
    logic [CNT_W-1:0] stall_cnt_p1;
    logic [CNT_W-1:0] flush_cnt_p1;
    logic             misaligned;

    assign misaligned = |pc_in[1:0];

    // IF -> ID boundary: flush beats stall, stall beats load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p1    <= '0;
            pc4_p1   <= '0;
            instr_p1 <= NOP;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
        end else if (flush) begin
            pc_p1    <= '0;
            pc4_p1   <= '0;
            instr_p1 <= NOP;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
        end else if (!stall) begin
            // Faulting PC still loads so the exception logic can report it
            pc_p1    <= pc_in;
            pc4_p1   <= pc_in + WIDTH'(4);
            instr_p1 <= misaligned ? NOP : instr_in;
            vld_p1   <= !misaligned;
            err_p1   <= misaligned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_p1 <= '0;
            flush_cnt_p1 <= '0;
        end else begin
            if (flush)
                flush_cnt_p1 <= sat_inc(flush_cnt_p1);
            else if (stall)
                stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end
    end

    assign pc_out       = pc_p1;
    assign pc_plus4_out = pc4_p1;
    assign instr_out    = instr_p1;
    assign valid_out    = vld_p1;
    assign addr_err_out = err_p1;
    assign stall_cnt    = stall_cnt_p1;
    assign flush_cnt    = flush_cnt_p1;

endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: directed and random stimulus against a behavioural model,
// with a 16-bit-counter instance and a 4-bit-counter instance driven in parallel.
module tb_if_id_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in, instr_in;
    logic        stall, flush;

    logic [31:0] pc_out, pc_plus4_out, instr_out;
    logic        valid_out, addr_err_out;
    logic [15:0] stall_cnt, flush_cnt;

    logic [31:0] pc_out4, pc_plus4_out4, instr_out4;
    logic        valid_out4, addr_err_out4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_vld, m_err;
    int          m_sc, m_fc;

    always #5 clk = ~clk;

    if_id_reg dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .instr_in(instr_in),
        .stall(stall), .flush(flush),
        .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .instr_out(instr_out),
        .valid_out(valid_out), .addr_err_out(addr_err_out),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .instr_in(instr_in),
        .stall(stall), .flush(flush),
        .pc_out(pc_out4), .pc_plus4_out(pc_plus4_out4), .instr_out(instr_out4),
        .valid_out(valid_out4), .addr_err_out(addr_err_out4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_pc4 = 0; m_instr = 32'h0; m_vld = 0; m_err = 0;
        m_sc = 0; m_fc = 0;
    endtask

    // Model: what the ID stage must hold after one edge with these inputs
    task automatic model_edge(input logic [31:0] pc, input logic [31:0] ins,
                              input logic st, input logic fl);
        if (fl) begin
            m_pc = 0; m_pc4 = 0; m_instr = 32'h0; m_vld = 0; m_err = 0;
            m_fc++;
        end else if (st) begin
            m_sc++;
        end else begin
            m_pc  = pc;
            m_pc4 = pc + 32'd4;
            if (pc % 4 == 0) begin
                m_instr = ins; m_vld = 1; m_err = 0;
            end else begin
                m_instr = 32'h0; m_vld = 0; m_err = 1;
            end
        end
    endtask

    task automatic step(input logic [31:0] pc, input logic [31:0] ins,
                        input logic st, input logic fl);
        pc_in = pc; instr_in = ins; stall = st; flush = fl;
        @(posedge clk);
        model_edge(pc, ins, st, fl);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},    pc_out,                 32'h0);
        check({tag, "_pc4"},   pc_plus4_out,           32'h0);
        check({tag, "_instr"}, instr_out,              32'h0);
        check({tag, "_vld"},   {31'b0, valid_out},     32'h0);
        check({tag, "_err"},   {31'b0, addr_err_out},  32'h0);
        check({tag, "_scnt"},  {16'b0, stall_cnt},     32'h0);
        check({tag, "_fcnt"},  {16'b0, flush_cnt},     32'h0);
        check({tag, "_scnt4"}, {28'b0, stall_cnt4},    32'h0);
    endtask

    // Single compare process: every falling edge while enabled
    always @(negedge clk) begin
        if (check_en) begin
            check("pc_out",       pc_out,                  m_pc);
            check("pc_plus4_out", pc_plus4_out,            m_pc4);
            check("instr_out",    instr_out,               m_instr);
            check("valid_out",    {31'b0, valid_out},      {31'b0, m_vld});
            check("addr_err_out", {31'b0, addr_err_out},   {31'b0, m_err});
            check("stall_cnt",    {16'b0, stall_cnt},      32'(sat(m_sc, 65535)));
            check("flush_cnt",    {16'b0, flush_cnt},      32'(sat(m_fc, 65535)));
            check("pc_out4",      pc_out4,                 m_pc);
            check("instr_out4",   instr_out4,              m_instr);
            check("stall_cnt4",   {28'b0, stall_cnt4},     32'(sat(m_sc, 15)));
            check("flush_cnt4",   {28'b0, flush_cnt4},     32'(sat(m_fc, 15)));
        end
    end

    initial begin
        rst_n = 1'b0; pc_in = 0; instr_in = 0; stall = 0; flush = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state("por");
        rst_n = 1'b1;
        check_en = 1'b1;

        // Load something, then reset asynchronously mid-cycle
        step(32'h00400100, 32'hDEADBEEF, 0, 0);
        check("pre_rst_vld", {31'b0, valid_out}, 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // First load after reset
        step(32'h00400000, 32'h20080005, 0, 0);
        check("ld_pc",    pc_out,             32'h00400000);
        check("ld_pc4",   pc_plus4_out,       32'h00400004);
        check("ld_instr", instr_out,          32'h20080005);
        check("ld_vld",   {31'b0, valid_out}, 32'h1);

        // Stall for three edges while pc_in keeps changing
        step(32'h00400008, 32'h8C090000, 0, 0);
        for (int i = 0; i < 3; i++)
            step(32'h00400010 + 32'(4 * i), $urandom, 1, 0);
        check("stall_pc",    pc_out,             32'h00400008);
        check("stall_instr", instr_out,          32'h8C090000);
        check("stall_cnt3",  {16'b0, stall_cnt}, 32'd3);
        step(32'h00400020, 32'h01095020, 0, 0);
        check("resume_pc",   pc_out,             32'h00400020);

        // Flush wins over stall
        step(32'h00400024, 32'hAAAA5555, 1, 1);
        check("fl_pc",    pc_out,             32'h0);
        check("fl_instr", instr_out,          32'h0);
        check("fl_vld",   {31'b0, valid_out}, 32'h0);
        check("fl_fcnt",  {16'b0, flush_cnt}, 32'd1);
        check("fl_scnt",  {16'b0, stall_cnt}, 32'd3);

        // PC+4 wraps to zero
        step(32'hFFFFFFFC, 32'h0BADF00D, 0, 0);
        check("wrap_pc4", pc_plus4_out,       32'h0);
        check("wrap_vld", {31'b0, valid_out}, 32'h1);

        // Misaligned fetch, then aligned load clears the error
        step(32'h00400002, 32'h12345678, 0, 0);
        check("mis_pc",    pc_out,                32'h00400002);
        check("mis_instr", instr_out,             32'h0);
        check("mis_vld",   {31'b0, valid_out},    32'h0);
        check("mis_err",   {31'b0, addr_err_out}, 32'h1);
        step(32'h00400004, 32'h12345678, 0, 0);
        check("mis_clr",   {31'b0, addr_err_out}, 32'h0);

        // 20 stall cycles: 4-bit counter pins at 15, 16-bit keeps counting
        for (int i = 0; i < 20; i++)
            step($urandom, $urandom, 1, 0);
        check("sat_scnt4", {28'b0, stall_cnt4}, 32'd15);
        check("sat_scnt",  {16'b0, stall_cnt},  32'd23);

        // Reset asserted in the middle of a stall
        stall = 1'b1;
        @(posedge clk);
        model_edge(pc_in, instr_in, 1, 0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_state("midstall_rst");
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            step(pc, $urandom, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2));
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_id_reg.md
# if_id_reg

IF/ID pipeline register of the pipelined MIPS core. Captures the fetch PC from the program counter and the word from instruction memory each cycle, and computes PC+4 for the decode stage. Honours hazard-unit stall (hold) and branch/jump flush (bubble). Keeps saturating stall/flush counters for performance debug.

## Interface
- WIDTH, 32, data/address width
- NOP, 32'h00000000, instruction word inserted on flush, reset and misaligned fetch
- CNT_W, 16, width of the performance counters

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- pc_in  in  WIDTH  current fetch PC (PC register output)
- instr_in  in  WIDTH  instruction memory read data for pc_in
- stall  in  1  hold IF/ID contents (load-use hazard)
- flush  in  1  squash IF/ID contents (taken branch/jump)
- pc_out  out  WIDTH  registered PC of the instruction in ID
- pc_plus4_out  out  WIDTH  registered pc_in + 4
- instr_out  out  WIDTH  registered instruction word
- valid_out  out  1  instr_out is a real instruction
- addr_err_out  out  1  captured fetch had pc_in[1:0] != 0
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flush cycles

## Operation
- Reset (rst_n=0, asynchronous, any time): pc_out=0, pc_plus4_out=0, instr_out=NOP, valid_out=0, addr_err_out=0, stall_cnt=0, flush_cnt=0. Counters are cleared only by reset.
- Per rising edge, priority is flush > stall > load:
  - flush=1: pc_out=0, pc_plus4_out=0, instr_out=NOP, valid_out=0, addr_err_out=0. Stall is ignored in that cycle.
  - stall=1, flush=0: all pipeline outputs hold their values.
  - Otherwise load: pc_out=pc_in, pc_plus4_out=pc_in+4, and then:
    - pc_in[1:0]==0: instr_out=instr_in, valid_out=1, addr_err_out=0.
    - pc_in[1:0]!=0: instr_out=NOP, valid_out=0, addr_err_out=1. PC fields still load so the exception logic sees the faulting PC.
- Arithmetic: pc_plus4_out is pc_in+4 modulo 2^WIDTH, so 32'hFFFFFFFC yields 0. No carry-out.
- Counters:
  - stall_cnt increments on each edge with stall=1 and flush=0.
  - flush_cnt increments on each edge with flush=1, whether or not stall is also asserted.
  - Both saturate at 2^CNT_W-1 and never wrap.
- The block has no other internal state. The only state machine is the implicit per-cycle choice of LOAD, HOLD or SQUASH.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- All outputs are registered. There is no combinational path from input to output.
- stall and flush are level-sensitive and take effect at the same edge they are sampled.
- A stall held for k cycles freezes the outputs for k edges. The load resumes on the first edge with stall=0.
- Reset asserted mid-stall or mid-flush clears all outputs immediately, without waiting for a clock edge. The first load after reset release happens on the first rising edge that sees rst_n=1.

## Test plan
- Reset: drive rst_n=0 mid-cycle with the register holding data -> all outputs 0/NOP at once, before the next edge. Release, drive pc_in=0x00400000, instr_in=0x20080005 -> after 1 edge: pc_out=0x00400000, pc_plus4_out=0x00400004, instr_out=0x20080005, valid_out=1.
- Stall: load 0x00400008/0x8C090000, then stall=1 for 3 cycles while pc_in changes -> outputs unchanged for 3 edges, stall_cnt=3. On stall=0 the new pc_in is captured.
- Flush priority: stall=1 and flush=1 on the same edge -> instr_out=NOP, valid_out=0, pc_out=0, flush_cnt+1, stall_cnt unchanged.
- Wrap: pc_in=0xFFFFFFFC -> pc_plus4_out=0x00000000, valid_out=1.
- Misaligned fetch: pc_in=0x00400002, instr_in=0x12345678 -> pc_out=0x00400002, instr_out=NOP, valid_out=0, addr_err_out=1. The next aligned load clears addr_err_out.
- Saturation: with CNT_W=4, hold stall=1 for 20 cycles -> stall_cnt stops at 15.
